// File: rtl/mprj_ckpt_pkg.sv
// Shared constants and types for the checkpoint pad driver: pad bit map,
// FSM encoding and the queued entry layout.
package mprj_ckpt_pkg;

   localparam int IO_W     = 38;
   localparam int CKPT_LSB = 16;
   localparam int CKPT_MSB = 31;
   localparam int STAT_LSB = 34;
   localparam int STAT_MSB = 37;

   localparam int CODE_W   = CKPT_MSB - CKPT_LSB + 1;
   localparam int STAT_W   = STAT_MSB - STAT_LSB + 1;
   localparam int ENTRY_W  = CODE_W + STAT_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } ckpt_state_e;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [STAT_W-1:0] status;
      logic              status_en;
   } ckpt_entry_t;

   // Pads owned by this block; everything else stays an undriven input.
   function automatic logic [IO_W-1:0] driven_mask();
      logic [IO_W-1:0] m;
      m = '0;
      m[CKPT_MSB:CKPT_LSB] = '1;
      m[STAT_MSB:STAT_LSB] = '1;
      return m;
   endfunction

endpackage

// File: rtl/mprj_ckpt_fifo.sv
// Generic synchronous FIFO, first-word-valid read. Pointers carry one extra
// wrap bit so full and empty come straight from registered state.
module mprj_ckpt_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mprj_ckpt_driver.sv
// Queues firmware checkpoint codes and presents each on the user pads for a
// guaranteed minimum number of cycles so a pad monitor cannot miss it.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing being held; pads keep the last code and status
//   HOLD  | a code is on the pads, hold_cnt counts down its dwell time
module mprj_ckpt_driver
   import mprj_ckpt_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             enable,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [15:0]      push_code,
   input  logic [3:0]       push_status,
   input  logic             push_status_en,
   output logic [IO_W-1:0]  io_out,
   output logic [IO_W-1:0]  io_oeb,
   output logic             busy
);

   localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IO_W-1:0]   PAD_MASK  = driven_mask();

   ckpt_state_e       state;
   ckpt_state_e       state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CODE_W-1:0] ckpt_reg;
   logic [STAT_W-1:0] stat_reg;

   ckpt_entry_t       wr_entry;
   ckpt_entry_t       head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              hold_done;
   logic              pad_drive;

   assign wr_entry = '{code: push_code, status: push_status, status_en: push_status_en};

   mprj_ckpt_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .push    (push_valid),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign push_ready = !fifo_full;
   assign hold_done  = (hold_cnt == '0);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (enable && !fifo_empty) state_nxt = HOLD;
         HOLD: if (hold_done && !(enable && !fifo_empty)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A pop happens on leaving IDLE or at the end of a hold with a successor
   // queued, which gives back-to-back codes with no gap cycle.
   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:    pop = enable && !fifo_empty;
         HOLD:    pop = enable && !fifo_empty && hold_done;
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         hold_cnt <= '0;
      end else if (pop) begin
         hold_cnt <= HOLD_LOAD;
      end else if (!hold_done) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ckpt_reg <= '0;
         stat_reg <= '0;
      end else if (pop) begin
         ckpt_reg <= head.code;
         if (head.status_en) stat_reg <= head.status;
      end
   end

   always_comb begin
      io_out                    = '0;
      io_out[CKPT_MSB:CKPT_LSB] = ckpt_reg;
      io_out[STAT_MSB:STAT_LSB] = stat_reg;
   end

   // Pads are released during reset regardless of enable.
   assign pad_drive = enable && !wb_rst_i;
   assign io_oeb    = pad_drive ? ~PAD_MASK : '1;

   assign busy = (state == HOLD) || !fifo_empty;

endmodule

// File: tb/tb_mprj_ckpt_driver.sv
// Directed bench for the checkpoint pad driver, DEPTH=4 and HOLD_CYCLES=16.
module tb_mprj_ckpt_driver;

   localparam logic [37:0] OEB_OFF = 38'h3F_FFFF_FFFF;
   localparam logic [37:0] OEB_ON  = 38'h03_0000_FFFF;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic        enable;
   logic        push_valid;
   logic        push_ready;
   logic [15:0] push_code;
   logic [3:0]  push_status;
   logic        push_status_en;
   logic [37:0] io_out;
   logic [37:0] io_oeb;
   logic        busy;

   int n_vec  = 0;
   int n_miss = 0;

   mprj_ckpt_driver #(
      .DEPTH       (4),
      .HOLD_CYCLES (16)
   ) dut (
      .wb_clk_i       (wb_clk_i),
      .wb_rst_i       (wb_rst_i),
      .enable         (enable),
      .push_valid     (push_valid),
      .push_ready     (push_ready),
      .push_code      (push_code),
      .push_status    (push_status),
      .push_status_en (push_status_en),
      .io_out         (io_out),
      .io_oeb         (io_oeb),
      .busy           (busy)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_vec(input string tag, input logic [37:0] obs, input logic [37:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [37:0] pads(input logic [15:0] c, input logic [3:0] s);
      return {s, 2'b00, c, 16'h0000};
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic push_one(input logic [15:0] c, input logic [3:0] s, input logic en);
      push_valid     = 1'b1;
      push_code      = c;
      push_status    = s;
      push_status_en = en;
      tick();
      push_valid     = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check_vec(tag, {37'd0, busy}, 38'd0);
   endtask

   logic [15:0] b_code [6];
   logic [3:0]  b_stat [6];
   logic        b_en   [6];
   logic [3:0]  b_pad  [6];
   int          acc_k  [6];

   initial begin
      int idx;
      logic rdy;

      wb_rst_i       = 1'b1;
      enable         = 1'b0;
      push_valid     = 1'b0;
      push_code      = '0;
      push_status    = '0;
      push_status_en = 1'b0;

      // 1. reset and enable
      repeat (3) tick();
      wb_rst_i = 1'b0;
      tick();
      check_vec("rst_io_out", io_out, 38'd0);
      check_vec("rst_io_oeb", io_oeb, OEB_OFF);
      check_vec("rst_ready", {37'd0, push_ready}, 38'd1);
      check_vec("rst_busy", {37'd0, busy}, 38'd0);
      enable = 1'b1;
      #1;
      check_vec("en_io_oeb", io_oeb, OEB_ON);
      check_vec("en_io_out", io_out, 38'd0);

      // 2. single push, one cycle of latency, 16-cycle dwell, retained after
      push_one(16'hAB40, 4'hA, 1'b1);
      check_vec("single_latency", io_out, 38'd0);
      check_vec("single_busy_q", {37'd0, busy}, 38'd1);
      tick();
      check_vec("single_first", io_out, pads(16'hAB40, 4'hA));
      for (int i = 0; i < 15; i++) begin
         tick();
         check_vec("single_hold", io_out, pads(16'hAB40, 4'hA));
         check_vec("single_busy", {37'd0, busy}, 38'd1);
      end
      tick();
      check_vec("single_idle_busy", {37'd0, busy}, 38'd0);
      check_vec("single_retained", io_out, pads(16'hAB40, 4'hA));

      // 4. status retention with status_en=0, then update
      push_one(16'h0009, 4'h3, 1'b0);
      tick();
      check_vec("stat_keep", io_out, pads(16'h0009, 4'hA));
      wait_idle("stat_keep_idle");
      push_one(16'hAB51, 4'h5, 1'b1);
      tick();
      check_vec("stat_update", io_out, pads(16'hAB51, 4'h5));
      wait_idle("stat_update_idle");

      // 3. six pushes on consecutive cycles, back-to-back dwell
      b_code = '{16'hAB40, 16'h0009, 16'hAB51, 16'h1111, 16'h2222, 16'h3333};
      b_stat = '{4'hA, 4'h0, 4'h5, 4'h0, 4'h0, 4'hC};
      b_en   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      b_pad  = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h5, 4'hC};
      acc_k  = '{-1, -1, -1, -1, -1, -1};
      idx = 0;
      for (int k = 0; k <= 97; k++) begin
         if (idx < 6) begin
            push_valid     = 1'b1;
            push_code      = b_code[idx];
            push_status    = b_stat[idx];
            push_status_en = b_en[idx];
         end else begin
            push_valid     = 1'b0;
         end
         rdy = push_ready;
         tick();
         if (push_valid && rdy) begin
            acc_k[idx] = k;
            idx++;
         end
         if (k >= 1 && k <= 96)
            check_vec("b2b_pads", io_out, pads(b_code[(k-1)/16], b_pad[(k-1)/16]));
         if (k == 4)  check_vec("b2b_full_ready", {37'd0, push_ready}, 38'd0);
         if (k == 16) check_vec("b2b_still_full", {37'd0, push_ready}, 38'd0);
         if (k == 17) check_vec("b2b_ready_back", {37'd0, push_ready}, 38'd1);
         if (k == 96) check_vec("b2b_busy_last", {37'd0, busy}, 38'd1);
         if (k == 97) begin
            check_vec("b2b_idle_busy", {37'd0, busy}, 38'd0);
            check_vec("b2b_retained", io_out, pads(16'h3333, 4'hC));
         end
      end
      push_valid = 1'b0;
      check_vec("b2b_fifth_acc", 38'(acc_k[4]), 38'd4);
      check_vec("b2b_sixth_acc", 38'(acc_k[5]), 38'd18);

      // 5. reset during third HOLD cycle with three entries queued
      push_one(16'hAB40, 4'hA, 1'b1);
      push_one(16'h0009, 4'h0, 1'b0);
      push_one(16'hAB51, 4'h5, 1'b1);
      push_one(16'h1111, 4'h0, 1'b0);
      check_vec("mid_pads", io_out, pads(16'hAB40, 4'hA));
      wb_rst_i       = 1'b1;
      push_valid     = 1'b1;
      push_code      = 16'h2222;
      push_status    = 4'h6;
      push_status_en = 1'b1;
      tick();
      check_vec("mid_rst_io_out", io_out, 38'd0);
      check_vec("mid_rst_ready", {37'd0, push_ready}, 38'd1);
      check_vec("mid_rst_busy", {37'd0, busy}, 38'd0);
      wb_rst_i   = 1'b0;
      push_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_vec("post_rst_io_out", io_out, 38'd0);
         check_vec("post_rst_busy", {37'd0, busy}, 38'd0);
      end

      // 6. enable gating with two entries queued
      push_one(16'h1111, 4'h7, 1'b1);
      push_one(16'h2222, 4'h0, 1'b0);
      push_one(16'h3333, 4'h9, 1'b1);
      check_vec("gate_first", io_out, pads(16'h1111, 4'h7));
      for (int k = 3; k <= 63; k++) begin
         enable = (k >= 31);
         tick();
         if (k <= 30) begin
            check_vec("gate_off_pads", io_out, pads(16'h1111, 4'h7));
            check_vec("gate_off_oeb", io_oeb, OEB_OFF);
            check_vec("gate_off_busy", {37'd0, busy}, 38'd1);
         end else if (k <= 46) begin
            check_vec("gate_resume_a", io_out, pads(16'h2222, 4'h7));
            check_vec("gate_on_oeb", io_oeb, OEB_ON);
         end else if (k <= 62) begin
            check_vec("gate_resume_b", io_out, pads(16'h3333, 4'h9));
         end else begin
            check_vec("gate_idle_busy", {37'd0, busy}, 38'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
